// File: rtl/rr_bus_arbiter_if.sv
// rr_bus_arbiter_if
//   Bundle shared by the requester channels and the RAM port of rr_bus_arbiter.
//   master : requester/RAM side (drives req, addr, mem_data)
//   slave  : arbiter side       (drives data, rdy, mem_addr, busy, grant_idx)
//   req       per-channel level request, bit i = channel i
//   addr      packed addresses, channel i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   data      packed latched read data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rdy       per-channel ready, sticky while req held
//   mem_addr  registered RAM address
//   mem_data  RAM read data
//   busy      read in flight
//   grant_idx channel owning the current or last read
interface rr_bus_arbiter_if #(
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
);
    localparam int GW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0]               req;
    logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] addr;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]    data;
    logic [NUM_CHANNELS-1:0]               rdy;
    logic [ADDRESS_WIDTH-1:0]              mem_addr;
    logic [DATA_WIDTH-1:0]                 mem_data;
    logic                                  busy;
    logic [GW-1:0]                         grant_idx;

    // The RAM read data is grouped with the requester side: both are inputs
    // to the arbiter.
    modport master (
        output req, addr, mem_data,
        input  data, rdy, mem_addr, busy, grant_idx
    );

    modport slave (
        input  req, addr, mem_data,
        output data, rdy, mem_addr, busy, grant_idx
    );
endinterface

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter
//   Shares one synchronous RAM read port among NUM_CHANNELS requesters.
//   One read is outstanding at a time. Each channel has a level req / sticky
//   rdy handshake and a latched data word. Winner selection is round-robin
//   from a pointer that moves past the last owner.
//   Build option: define RR_BUS_ARBITER_FIXED_PRIO_EN for fixed priority
//   (lowest eligible index wins, no RR pointer); timing is unchanged.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  rr_bus_arbiter_if.slave (req/addr/data/rdy, RAM port, busy, grant_idx)
module rr_bus_arbiter #(
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_LATENCY   = 1
) (
    input logic              clk,
    input logic              rst,
    rr_bus_arbiter_if.slave  bus
);
    localparam int GW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  state, state_next;
    logic [2:0]              cnt;
    logic [NUM_CHANNELS-1:0] elig;
    logic [GW-1:0]           winner;
    logic                    any_elig;
    logic                    capture;
`ifndef RR_BUS_ARBITER_FIXED_PRIO_EN
    logic [GW-1:0]           ptr;
`endif

    // Arbitration only happens in IDLE, so there is no current owner to
    // exclude; a channel already served waits for its own req drop.
    assign elig    = bus.req & ~bus.rdy;
    assign capture = (state == S_WAIT) && (cnt == 3'(MEM_LATENCY));

    always_comb begin
        int j;
        j        = 0;
        winner   = '0;
        any_elig = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
`ifdef RR_BUS_ARBITER_FIXED_PRIO_EN
            j = k;
`else
            j = int'(ptr) + k;
            if (j >= NUM_CHANNELS) j = j - NUM_CHANNELS;
`endif
            if (!any_elig && elig[j]) begin
                any_elig = 1'b1;
                winner   = GW'(j);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (any_elig) state_next = S_WAIT;
            S_WAIT:  if (capture)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy = (state == S_WAIT);
    end

    // Datapath: address issue, latency count, capture and rdy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_addr  <= '0;
            bus.grant_idx <= '0;
            bus.data      <= '0;
            bus.rdy       <= '0;
            cnt           <= '0;
`ifndef RR_BUS_ARBITER_FIXED_PRIO_EN
            ptr           <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++)
                if (!bus.req[i]) bus.rdy[i] <= 1'b0;

            if (state == S_IDLE && any_elig) begin
                // Address is latched once; later addr changes are ignored.
                bus.mem_addr  <= bus.addr[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                bus.grant_idx <= winner;
                cnt           <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + 3'd1;
                if (capture) begin
                    // A withdrawn request drops the returning word silently.
                    if (bus.req[bus.grant_idx]) begin
                        bus.data[int'(bus.grant_idx)*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_data;
                        bus.rdy[bus.grant_idx] <= 1'b1;
                    end
`ifndef RR_BUS_ARBITER_FIXED_PRIO_EN
                    ptr <= (bus.grant_idx == GW'(NUM_CHANNELS-1)) ? '0
                                                                  : bus.grant_idx + 1'b1;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter
//   Directed bench: dut1 uses MEM_LATENCY=1, dut3 uses MEM_LATENCY=3.
//   RAM content: addr 0x7F -> 0x3C, otherwise addr ^ 0xB7.
module tb_rr_bus_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
`ifdef RR_BUS_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter_if #(.NUM_CHANNELS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    rr_bus_arbiter_if #(.NUM_CHANNELS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    rr_bus_arbiter #(.NUM_CHANNELS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    rr_bus_arbiter #(.NUM_CHANNELS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));

    function automatic logic [7:0] ram_f(input logic [7:0] a);
        return (a == 8'h7F) ? 8'h3C : (a ^ 8'hB7);
    endfunction

    // RAM models: latency counted from the edge that samples mem_addr.
    logic [7:0] r1, r2;
    always @(posedge clk) bus1.mem_data <= ram_f(bus1.mem_addr);
    always @(posedge clk) begin
        r1            <= ram_f(bus3.mem_addr);
        r2            <= r1;
        bus3.mem_data <= r2;
    end

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] addr;
        logic [3:0]  rdy;
        logic        busy;
        logic [1:0]  gnt;
        logic [7:0]  maddr;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [3:0] r, input logic b,
                        input logic [1:0] g, input logic [7:0] m, input logic [31:0] d);
        chk({tag, " rdy"},   32'(bus1.rdy),       32'(r));
        chk({tag, " busy"},  32'(bus1.busy),      32'(b));
        chk({tag, " gnt"},   32'(bus1.grant_idx), 32'(g));
        chk({tag, " maddr"}, 32'(bus1.mem_addr),  32'(m));
        chk({tag, " data"},  bus1.data,           d);
    endtask

    task automatic drive1(input logic [3:0] r, input logic [31:0] a);
        bus1.req  = r;
        bus1.addr = a;
    endtask

    initial begin
        logic [1:0] g_c, g_d;
        logic [7:0] m_c, m_d;
        logic [3:0] r_c, r_d;

        // Single read, reset between, then in-order grants 0,1,2,3,0 with
        // each served channel leaving the request set.
        tbl[0]  = '{1'b0, 4'b0001, 32'h40302012, 4'b0000, 1'b1, 2'd0, 8'h12, 32'h0};
        tbl[1]  = '{1'b0, 4'b0001, 32'h40302012, 4'b0000, 1'b1, 2'd0, 8'h12, 32'h0};
        tbl[2]  = '{1'b0, 4'b0001, 32'h40302012, 4'b0001, 1'b0, 2'd0, 8'h12, 32'h000000A5};
        tbl[3]  = '{1'b0, 4'b0000, 32'h40302012, 4'b0000, 1'b0, 2'd0, 8'h12, 32'h000000A5};
        tbl[4]  = '{1'b0, 4'b0000, 32'h40302012, 4'b0000, 1'b0, 2'd0, 8'h12, 32'h000000A5};
        tbl[5]  = '{1'b1, 4'b0000, 32'h40302010, 4'b0000, 1'b0, 2'd0, 8'h00, 32'h0};
        tbl[6]  = '{1'b0, 4'b1111, 32'h40302010, 4'b0000, 1'b1, 2'd0, 8'h10, 32'h0};
        tbl[7]  = '{1'b0, 4'b1111, 32'h40302010, 4'b0000, 1'b1, 2'd0, 8'h10, 32'h0};
        tbl[8]  = '{1'b0, 4'b1111, 32'h40302010, 4'b0001, 1'b0, 2'd0, 8'h10, 32'h000000A7};
        tbl[9]  = '{1'b0, 4'b1110, 32'h40302010, 4'b0000, 1'b1, 2'd1, 8'h20, 32'h000000A7};
        tbl[10] = '{1'b0, 4'b1110, 32'h40302010, 4'b0000, 1'b1, 2'd1, 8'h20, 32'h000000A7};
        tbl[11] = '{1'b0, 4'b1110, 32'h40302010, 4'b0010, 1'b0, 2'd1, 8'h20, 32'h000097A7};
        tbl[12] = '{1'b0, 4'b1100, 32'h40302010, 4'b0000, 1'b1, 2'd2, 8'h30, 32'h000097A7};
        tbl[13] = '{1'b0, 4'b1100, 32'h40302010, 4'b0000, 1'b1, 2'd2, 8'h30, 32'h000097A7};
        tbl[14] = '{1'b0, 4'b1100, 32'h40302010, 4'b0100, 1'b0, 2'd2, 8'h30, 32'h008797A7};
        tbl[15] = '{1'b0, 4'b1000, 32'h40302010, 4'b0000, 1'b1, 2'd3, 8'h40, 32'h008797A7};
        tbl[16] = '{1'b0, 4'b1000, 32'h40302010, 4'b0000, 1'b1, 2'd3, 8'h40, 32'h008797A7};
        tbl[17] = '{1'b0, 4'b1000, 32'h40302010, 4'b1000, 1'b0, 2'd3, 8'h40, 32'hF78797A7};
        tbl[18] = '{1'b0, 4'b0001, 32'h40302010, 4'b0000, 1'b1, 2'd0, 8'h10, 32'hF78797A7};
        tbl[19] = '{1'b0, 4'b0001, 32'h40302010, 4'b0000, 1'b1, 2'd0, 8'h10, 32'hF78797A7};
        tbl[20] = '{1'b0, 4'b0001, 32'h40302010, 4'b0001, 1'b0, 2'd0, 8'h10, 32'hF78797A7};

        rst = 1'b1;
        drive1(4'b0000, 32'h0);
        bus3.req  = 4'b0000;
        bus3.addr = 32'h0;
        tick(); tick(); tick();
        chk1("reset", 4'b0000, 1'b0, 2'd0, 8'h00, 32'h0);
        chk("reset3 busy", 32'(bus3.busy), 32'h0);
        chk("reset3 rdy",  32'(bus3.rdy),  32'h0);

        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst;
            drive1(tbl[i].req, tbl[i].addr);
            tick();
            chk1($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].busy, tbl[i].gnt,
                 tbl[i].maddr, tbl[i].data);
        end

        // Contention after the pointer moves past channel 2.
        r_c = FIXED ? 4'b0001 : 4'b1000;
        g_c = FIXED ? 2'd0 : 2'd3;
        m_c = FIXED ? 8'h10 : 8'h40;
        drive1(4'b0000, 32'h40302010); tick();
        chk1("c0", 4'b0000, 1'b0, 2'd0, 8'h10, 32'hF78797A7);
        drive1(4'b0100, 32'h40302010); tick();
        chk1("c1", 4'b0000, 1'b1, 2'd2, 8'h30, 32'hF78797A7);
        tick(); tick();
        chk1("c3", 4'b0100, 1'b0, 2'd2, 8'h30, 32'hF78797A7);
        drive1(4'b1001, 32'h40302010); tick();
        chk1("c4", 4'b0000, 1'b1, g_c, m_c, 32'hF78797A7);
        tick(); tick();
        chk1("c6", r_c, 1'b0, g_c, m_c, 32'hF78797A7);
        drive1(4'b0000, 32'h40302010); tick();
        chk1("c7", 4'b0000, 1'b0, g_c, m_c, 32'hF78797A7);

        // Withdrawal: channel 1 drops req after G; its word (0xE2) is dropped.
        r_d = FIXED ? 4'b0001 : 4'b0100;
        g_d = FIXED ? 2'd0 : 2'd2;
        m_d = FIXED ? 8'h10 : 8'h30;
        drive1(4'b0010, 32'h40305510); tick();
        chk1("d0", 4'b0000, 1'b1, 2'd1, 8'h55, 32'hF78797A7);
        drive1(4'b0101, 32'h40305510); tick();
        chk1("d1", 4'b0000, 1'b1, 2'd1, 8'h55, 32'hF78797A7);
        tick();
        chk1("d2", 4'b0000, 1'b0, 2'd1, 8'h55, 32'hF78797A7);
        tick();
        chk1("d3", 4'b0000, 1'b1, g_d, m_d, 32'hF78797A7);
        tick(); tick();
        chk1("d5", r_d, 1'b0, g_d, m_d, 32'hF78797A7);
        drive1(4'b0000, 32'h40305510); tick();

        // Reset mid-read, then restart from pointer 0.
        drive1(4'b0001, 32'h40305510); tick();
        chk1("e0", 4'b0000, 1'b1, 2'd0, 8'h10, 32'hF78797A7);
        rst = 1'b1; tick();
        chk1("e1", 4'b0000, 1'b0, 2'd0, 8'h00, 32'h0);
        rst = 1'b0;
        drive1(4'b1110, 32'h40305510); tick();
        chk1("e2", 4'b0000, 1'b1, 2'd1, 8'h55, 32'h0);
        tick(); tick();
        chk1("e4", 4'b0010, 1'b0, 2'd1, 8'h55, 32'h0000E200);
        drive1(4'b0000, 32'h40305510); tick();

        // Latency 3: address held for the whole read even though addr and
        // req wiggle; capture uses req at the capture edge.
        bus3.req  = 4'b0001;
        bus3.addr = 32'h0000007F;
        tick();
        chk("f0 maddr", 32'(bus3.mem_addr), 32'h7F);
        chk("f0 busy",  32'(bus3.busy),     32'h1);
        bus3.addr = 32'h00000055;
        for (int k = 1; k <= 3; k++) begin
            bus3.req = (k == 2) ? 4'b0000 : 4'b0001;
            tick();
            chk($sformatf("f%0d maddr", k), 32'(bus3.mem_addr), 32'h7F);
            chk($sformatf("f%0d busy", k),  32'(bus3.busy),     32'h1);
            chk($sformatf("f%0d rdy", k),   32'(bus3.rdy),      32'h0);
        end
        tick();
        chk("f4 rdy",  32'(bus3.rdy),  32'h1);
        chk("f4 busy", 32'(bus3.busy), 32'h0);
        chk("f4 data", bus3.data,      32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
